// File: rtl/stereo_cam_pkg.sv
// Shared definitions for the stereo camera frame store.
// Holds the default frame geometry, the sink state encoding and the
// packed {left, right} pixel word written to pixel memory.
package stereo_cam_pkg;

    localparam int unsigned DEF_WIDTH      = 320;  // pixels per row per eye
    localparam int unsigned DEF_HEIGHT     = 480;  // rows per frame
    localparam int unsigned DEF_ADDR_W     = 18;   // memory word address width
    localparam int unsigned DEF_FIFO_DEPTH = 16;   // write FIFO entries
    localparam int unsigned COORD_W        = 10;   // x / y coordinate width
    localparam int unsigned LUMA_W         = 8;    // per-eye luma width

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FLUSH   = 2'd2
    } sink_state_e;

    typedef struct packed {
        logic [LUMA_W-1:0] left;
        logic [LUMA_W-1:0] right;
    } pix_word_t;

    localparam int unsigned PIX_W = $bits(pix_word_t);

endpackage

// File: rtl/stereo_frame_sink_if.sv
// Pixel-memory write port: req/ack handshake carrying one packed
// {left, right} word per transfer.
//   mem_req  : write request, held with addr/data until acked
//   mem_addr : word address
//   mem_data : {left, right}
//   mem_ack  : memory accepted the current word
// master = frame sink, slave = pixel memory.
interface stereo_frame_sink_if
    import stereo_cam_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_data;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        output mem_data,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_data,
        output mem_ack
    );
endinterface

// File: rtl/stereo_frame_sink_sync_fifo.sv
// Single-clock FIFO with registered head word and registered flags.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write strobe and data (ignored when full unless popping)
//   pop        : read strobe (ignored when empty); dout advances next cycle
//   dout       : current head word (registered)
//   full/empty : registered occupancy flags
// A push and pop in the same cycle on a full FIFO both succeed.
module sync_fifo #(
    parameter int unsigned DATA_W = 34,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              pop_ok_c, push_ok_c;

    assign pop_ok_c  = pop && !empty_q;
    assign push_ok_c = push && (!full_q || pop_ok_c);

    // Next pointers, occupancy and the head word as it will look next cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok_c) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_ok_c) - CNT_W'(pop_ok_c);
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
        dout_d  = mem_d[rd_ptr_d];
    end

    // Storage needs no reset: it is only read while occupied.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign dout  = dout_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/stereo_frame_sink.sv
// Write side of the stereo frame store. Checks that the dual-camera pixel
// stream arrives in raster order, packs each left/right pair into a word
// and writes it to pixel memory at y*WIDTH + x over a req/ack handshake.
//   cam_clk, reset_n        : clock, async active-low reset
//   in_x/in_y               : pixel coordinates
//   in_left/in_right        : per-eye luma
//   in_is_val               : stream qualifier
//   mem                     : memory write port (master side)
//   frame_done              : one-cycle pulse after a frame's last ack
//   frame_count             : completed frames (wraps)
//   err_seq / overflow      : sticky out-of-order / dropped-pixel flags
//   busy                    : capturing or flushing a frame
//   drop_count              : only with STEREO_SINK_STATS_EN; saturating
//                             count of FIFO-full drops and rejected pixels
module stereo_frame_sink
    import stereo_cam_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned HEIGHT     = DEF_HEIGHT,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic               cam_clk,
    input  logic               reset_n,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    input  logic [LUMA_W-1:0]  in_left,
    input  logic [LUMA_W-1:0]  in_right,
    input  logic               in_is_val,
    stereo_frame_sink_if.master mem,
    output logic               frame_done,
    output logic [7:0]         frame_count,
    output logic               err_seq,
    output logic               overflow,
    output logic               busy
`ifdef STEREO_SINK_STATS_EN
    ,
    output logic [15:0]        drop_count
`endif
);
    localparam int unsigned ENTRY_W = PIX_W + ADDR_W;

    sink_state_e        state_q, state_d;
    logic [COORD_W-1:0] ex_q, ex_d;
    logic [COORD_W-1:0] ey_q, ey_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic               mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    pix_word_t          mem_data_q, mem_data_d;
    logic               frame_done_q, frame_done_d;
    logic [7:0]         frame_count_q, frame_count_d;
    logic               err_seq_q, err_seq_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;
`ifdef STEREO_SINK_STATS_EN
    logic [15:0]        drop_count_q, drop_count_d;
    logic               drop_c;
`endif

    logic               match_c, row_end_c, last_c, accept_c;
    logic               push_c, pop_c;
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_din_c, fifo_dout;
    pix_word_t          pix_c;

    assign pix_c      = '{left: in_left, right: in_right};
    assign fifo_din_c = {pix_c, wr_addr_q};

    // Counters sit at (0,0)/addr 0 outside CAPTURE, so the same compare
    // detects both the frame start in IDLE and the next pixel in CAPTURE.
    assign match_c   = in_is_val && (in_x == ex_q) && (in_y == ey_q);
    assign row_end_c = (ex_q == COORD_W'(WIDTH - 1));
    assign last_c    = row_end_c && (ey_q == COORD_W'(HEIGHT - 1));

    // Refill the output stage whenever it is empty or being acked this cycle.
    assign pop_c = !fifo_empty && (!mem_req_q || mem.mem_ack);

    sync_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (cam_clk),
        .rst_n (reset_n),
        .push  (push_c),
        .din   (fifo_din_c),
        .pop   (pop_c),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Frame FSM, position counters and memory output stage.
    always_comb begin
        state_d       = state_q;
        ex_d          = ex_q;
        ey_d          = ey_q;
        wr_addr_d     = wr_addr_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        mem_data_d    = mem_data_q;
        frame_done_d  = 1'b0;
        frame_count_d = frame_count_q;
        err_seq_d     = err_seq_q;
        overflow_d    = overflow_q;
        accept_c      = 1'b0;
        push_c        = 1'b0;
`ifdef STEREO_SINK_STATS_EN
        drop_c        = 1'b0;
`endif

        unique case (state_q)
            IDLE: begin
                if (match_c) begin
                    accept_c = 1'b1;
                    state_d  = last_c ? FLUSH : CAPTURE;
                end
            end
            CAPTURE: begin
                if (in_is_val) begin
                    if (match_c) begin
                        accept_c = 1'b1;
                        if (last_c) begin
                            state_d = FLUSH;
                        end
                    end else begin
                        // Out of order: abandon the frame, let queued words drain.
                        err_seq_d = 1'b1;
                        state_d   = IDLE;
`ifdef STEREO_SINK_STATS_EN
                        drop_c    = 1'b1;
`endif
                    end
                end
            end
            FLUSH: begin
                if (fifo_empty && !mem_req_q) begin
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 8'd1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A dropped pixel still advances the counters to keep addresses aligned.
        if (accept_c) begin
            if (fifo_full && !pop_c) begin
                overflow_d = 1'b1;
`ifdef STEREO_SINK_STATS_EN
                drop_c     = 1'b1;
`endif
            end else begin
                push_c = 1'b1;
            end
            ex_d      = row_end_c ? '0 : ex_q + COORD_W'(1);
            ey_d      = row_end_c ? ey_q + COORD_W'(1) : ey_q;
            wr_addr_d = wr_addr_q + ADDR_W'(1);
        end

        if (state_d != CAPTURE) begin
            ex_d      = '0;
            ey_d      = '0;
            wr_addr_d = '0;
        end

        if (pop_c) begin
            mem_req_d  = 1'b1;
            mem_addr_d = fifo_dout[ADDR_W-1:0];
            mem_data_d = fifo_dout[ENTRY_W-1:ADDR_W];
        end else if (mem.mem_ack) begin
            mem_req_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

`ifdef STEREO_SINK_STATS_EN
    // Saturating drop statistics.
    always_comb begin
        drop_count_d = drop_count_q;
        if (drop_c && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge cam_clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count_q <= '0;
        end else begin
            drop_count_q <= drop_count_d;
        end
    end

    assign drop_count = drop_count_q;
`endif

    always_ff @(posedge cam_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            ex_q          <= '0;
            ey_q          <= '0;
            wr_addr_q     <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            err_seq_q     <= 1'b0;
            overflow_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            ex_q          <= ex_d;
            ey_q          <= ey_d;
            wr_addr_q     <= wr_addr_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_q    <= mem_data_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            err_seq_q     <= err_seq_d;
            overflow_q    <= overflow_d;
            busy_q        <= busy_d;
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_data = mem_data_q;
    assign frame_done   = frame_done_q;
    assign frame_count  = frame_count_q;
    assign err_seq      = err_seq_q;
    assign overflow     = overflow_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_stereo_frame_sink.sv
// Directed bench for stereo_frame_sink on a reduced 32x6 frame.
// Expected memory words are queued as pixels are driven and checked as
// the sink writes them out.
module tb_stereo_frame_sink;

    localparam int unsigned W     = 32;
    localparam int unsigned H     = 6;
    localparam int unsigned AW    = 18;
    localparam int unsigned DEPTH = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } exp_t;

    logic        cam_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  in_x = '0;
    logic [9:0]  in_y = '0;
    logic [7:0]  in_left = '0;
    logic [7:0]  in_right = '0;
    logic        in_is_val = 1'b0;
    logic        frame_done;
    logic [7:0]  frame_count;
    logic        err_seq;
    logic        overflow;
    logic        busy;
`ifdef STEREO_SINK_STATS_EN
    logic [15:0] drop_count;
`endif

    stereo_frame_sink_if #(.ADDR_W(AW)) mem_if ();

    stereo_frame_sink #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .ADDR_W     (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .cam_clk     (cam_clk),
        .reset_n     (reset_n),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_left     (in_left),
        .in_right    (in_right),
        .in_is_val   (in_is_val),
        .mem         (mem_if),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .err_seq     (err_seq),
        .overflow    (overflow),
`ifdef STEREO_SINK_STATS_EN
        .drop_count  (drop_count),
`endif
        .busy        (busy)
    );

    always #5 cam_clk = ~cam_clk;

    int   n_checks = 0;
    int   n_pass = 0;
    exp_t exp_q[$];
    int   writes = 0;
    int   done_cnt = 0;
    int   skipped = 0;
    int   cyc = 0;
    int   last_xfer_cyc = -100;
    logic [AW-1:0] last_addr = '0;
    bit   allow_skip = 1'b0;
    bit   pend = 1'b0;
    bit   prev_done = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    logic [15:0]   pend_data = '0;
    int   stall_left = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Output monitor: handshake stability, frame_done shape and scoreboard.
    always @(negedge cam_clk) begin
        exp_t e;
        cyc++;
        if (!reset_n) begin
            pend      = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (pend) begin
                check("stall_req_held", 64'(mem_if.mem_req), 64'd1);
                check("stall_addr_stable", 64'(mem_if.mem_addr), 64'(pend_addr));
                check("stall_data_stable", 64'(mem_if.mem_data), 64'(pend_data));
            end
            if (frame_done) begin
                check("done_single_cycle", 64'(prev_done), 64'd0);
                check("done_after_last_ack", 64'(cyc - last_xfer_cyc), 64'd2);
                done_cnt++;
            end
            prev_done = frame_done;
            if (mem_if.mem_req && mem_if.mem_ack) begin
                writes++;
                last_addr     = mem_if.mem_addr;
                last_xfer_cyc = cyc;
                check("write_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    if (allow_skip) begin
                        while (exp_q.size() > 1 && exp_q[0].addr != mem_if.mem_addr) begin
                            void'(exp_q.pop_front());
                            skipped++;
                        end
                    end
                    e = exp_q.pop_front();
                    check("write_addr", 64'(mem_if.mem_addr), 64'(e.addr));
                    check("write_data", 64'(mem_if.mem_data), 64'(e.data));
                end
            end
            pend      = mem_if.mem_req && !mem_if.mem_ack;
            pend_addr = mem_if.mem_addr;
            pend_data = mem_if.mem_data;
        end
    end

    // One cycle of stimulus; mem_ack is held low while a stall is running.
    task automatic tick();
        @(posedge cam_clk);
        #1;
        mem_if.mem_ack = (stall_left == 0);
        if (stall_left > 0) stall_left--;
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            in_is_val = 1'b0;
        end
    endtask

    task automatic send_pix(input int x, input int y, input bit exp_wr);
        exp_t e;
        tick();
        in_x      = 10'(x);
        in_y      = 10'(y);
        in_left   = 8'($urandom);
        in_right  = 8'($urandom);
        in_is_val = 1'b1;
        if (exp_wr) begin
            e.addr = AW'(y * W + x);
            e.data = {in_left, in_right};
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame(input bit hblank, input int stall_at, input int stall_len);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (y * W + x == stall_at) stall_left = stall_len;
                send_pix(x, y, 1'b1);
            end
            if (hblank) blank(2);
        end
        blank(1);
    endtask

    task automatic wait_done(input int budget);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < budget) begin
            tick();
            n++;
        end
        blank(4);
        check("frame_done_pulses", 64'(done_cnt - start), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"}, 64'(mem_if.mem_req), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_if.mem_addr), 64'd0);
        check({tag, "_mem_data"}, 64'(mem_if.mem_data), 64'd0);
        check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        check({tag, "_frame_count"}, 64'(frame_count), 64'd0);
        check({tag, "_err_seq"}, 64'(err_seq), 64'd0);
        check({tag, "_overflow"}, 64'(overflow), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
`ifdef STEREO_SINK_STATS_EN
        check({tag, "_drop_count"}, 64'(drop_count), 64'd0);
`endif
    endtask

    initial begin
        int writes0;
        int dones0;
        mem_if.mem_ack = 1'b1;

        // Reset values
        repeat (3) @(posedge cam_clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Full frame with ack high and horizontal blanking
        writes0 = writes;
        send_frame(1'b1, -1, 0);
        wait_done(200);
        check("f1_writes", 64'(writes - writes0), 64'(W * H));
        check("f1_last_addr", 64'(last_addr), 64'(W * H - 1));
        check("f1_frame_count", 64'(frame_count), 64'd1);
        check("f1_err_seq", 64'(err_seq), 64'd0);
        check("f1_overflow", 64'(overflow), 64'd0);
        check("f1_busy", 64'(busy), 64'd0);
        check("f1_queue_empty", 64'(exp_q.size()), 64'd0);

        // Stream joined mid-row: ignored until the next frame start
        writes0 = writes;
        for (int y = 0; y < 2; y++)
            for (int x = 5; x < W; x++) send_pix(x, y, 1'b0);
        blank(6);
        check("late_no_writes", 64'(writes - writes0), 64'd0);
        check("late_busy", 64'(busy), 64'd0);
        check("late_err_seq", 64'(err_seq), 64'd0);
        send_frame(1'b0, -1, 0);
        wait_done(200);
        check("late_frame_count", 64'(frame_count), 64'd2);
        check("late_queue_empty", 64'(exp_q.size()), 64'd0);

        // (10,3) followed by (12,3): sequence error, frame abandoned
        dones0 = done_cnt;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                if (!(y == 3 && x == 11))
                    send_pix(x, y, (y < 3) || (y == 3 && x <= 10));
        blank(30);
        check("seq_err_seq", 64'(err_seq), 64'd1);
        check("seq_last_addr", 64'(last_addr), 64'(3 * W + 10));
        check("seq_queue_empty", 64'(exp_q.size()), 64'd0);
        check("seq_no_done", 64'(done_cnt - dones0), 64'd0);
        check("seq_frame_count", 64'(frame_count), 64'd2);
        check("seq_busy", 64'(busy), 64'd0);
`ifdef STEREO_SINK_STATS_EN
        check("seq_drop_count", 64'(drop_count), 64'd1);
`endif
        send_frame(1'b1, -1, 0);
        wait_done(200);
        check("seq_next_frame_count", 64'(frame_count), 64'd3);

        // 40-cycle ack stall mid-row with continuous input
        allow_skip = 1'b1;
        skipped    = 0;
        send_frame(1'b0, W + 5, 40);
        wait_done(300);
        allow_skip = 1'b0;
        check("stall_overflow", 64'(overflow), 64'd1);
        check("stall_dropped_some", 64'(skipped > 0), 64'd1);
        check("stall_last_addr", 64'(last_addr), 64'(W * H - 1));
        check("stall_queue_empty", 64'(exp_q.size()), 64'd0);
        check("stall_frame_count", 64'(frame_count), 64'd4);
`ifdef STEREO_SINK_STATS_EN
        check("stall_drop_count", 64'(drop_count), 64'(1 + skipped));
`endif

        // Reset while flushing with words still queued
        send_frame(1'b0, W * H - 8, 1000);
        check("flush_busy", 64'(busy), 64'd1);
        check("flush_req", 64'(mem_if.mem_req), 64'd1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midflush");
        exp_q.delete();
        stall_left = 0;
        blank(2);
        reset_n = 1'b1;
        send_frame(1'b1, -1, 0);
        wait_done(200);
        check("post_reset_frame_count", 64'(frame_count), 64'd1);
        check("post_reset_overflow", 64'(overflow), 64'd0);
        check("post_reset_err_seq", 64'(err_seq), 64'd0);
        check("post_reset_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stereo_frame_sink.md
# stereo_frame_sink

Receives the simulated dual-camera pixel stream (x, y, left, right, valid), checks that the pixels arrive in raster order, and packs each left/right pair into a 16-bit word. Each word is written to external pixel memory over a req/ack handshake. The block sits downstream of the NTSC dual-cam emulator on the camera clock and is the write side of the stereo frame store that the disparity logic later reads.

## Interface
- WIDTH, 320: pixels per row per eye.
- HEIGHT, 480: rows per frame.
- ADDR_W, 18: memory word address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT.
- FIFO_DEPTH, 16: write FIFO entries; power of two, ≥ 4.

- cam_clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_x  in  10  pixel column, 0..WIDTH-1.
- in_y  in  10  pixel row, 0..HEIGHT-1.
- in_left  in  8  left-eye luma.
- in_right  in  8  right-eye luma.
- in_is_val  in  1  stream qualifier; other inputs are ignored when low.
- mem_req  out  1  write request.
- mem_addr  out  ADDR_W  word address, y*WIDTH + x.
- mem_data  out  16  {left, right}.
- mem_ack  in  1  memory accepted the current word.
- frame_done  out  1  one-cycle pulse after the last word of a frame is acked.
- frame_count  out  8  completed frames, wraps at 255→0.
- err_seq  out  1  sticky flag: out-of-order pixel seen.
- overflow  out  1  sticky flag: pixel dropped because the FIFO was full.
- busy  out  1  high in CAPTURE or FLUSH.

## Operation
- Reset values: mem_req=0, mem_addr=0, mem_data=0, frame_done=0, frame_count=0, err_seq=0, overflow=0, busy=0. The FIFO is empty and the state is IDLE.
- States and transitions:
  - IDLE → CAPTURE on a valid pixel with x=0, y=0. That pixel is captured. All other valid pixels are discarded silently.
  - CAPTURE: each valid pixel is compared against the expected (ex, ey) counters.
    - Match: push {left, right, addr} into the FIFO and advance the counters. ex wraps WIDTH-1→0 and increments ey.
    - The match at (WIDTH-1, HEIGHT-1) moves the block to FLUSH.
    - Mismatch: set err_seq, do not push, go to IDLE (resync on the next frame). Words already in the FIFO still drain.
  - FLUSH: input is ignored. When the FIFO is empty and no request is outstanding: pulse frame_done, increment frame_count, go to IDLE.
- Address is a running counter, cleared on the frame start and incremented per pushed pixel. There is no multiplier.
- FIFO full during CAPTURE with a matching pixel:
  - The pixel is dropped, overflow is set, and the counters still advance, so the address stays aligned.
  - The frame still completes and frame_done still fires.
- Sticky flags clear only on reset.
- Valid-low cycles (blanking) are allowed anywhere and do not affect state.

## Timing
- Handshake:
  - When asserted, mem_req stays high with mem_addr/mem_data stable until mem_ack is sampled high on a rising edge.
  - That transfer pops the FIFO. If the FIFO has another word, the next word is presented on the following cycle with mem_req held high.
  - mem_ack while mem_req=0 is ignored.
  - Throughput is one word per cycle with mem_ack tied high.
- Latency: a pixel accepted at edge N drives mem_req at edge N+1 at the earliest (registered FIFO output).
- Simultaneous push and pop when full: the pop is processed first, so the push succeeds with no overflow.
- frame_done asserts on the edge after the final ack and lasts exactly one cycle.
- Asynchronous reset mid-frame:
  - All outputs go to their reset values immediately.
  - An outstanding mem_req is abandoned; the memory side must tolerate this.

## Configuration
- STEREO_SINK_STATS_EN defined: adds output drop_count (16 bits). It counts FIFO-full drops plus discarded mismatched pixels, saturates at 0xFFFF, and is cleared by reset.
- Not defined: the port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package stereo_cam_pkg holds:
  - WIDTH/HEIGHT defaults;
  - the state enum {IDLE, CAPTURE, FLUSH};
  - the packed pixel word type {left, right}.
- One sub-module, sync_fifo: a parameterised width/depth single-clock FIFO with full/empty and registered output. The sink instantiates it with width 16+ADDR_W.

## Test plan
- Full 320×480 frame with mem_ack tied high:
  - 153600 writes;
  - addresses run 0..153599;
  - mem_data={left, right} for every pixel;
  - one frame_done pulse; frame_count=1; err_seq=0, overflow=0.
- Stream starting at (5, 0): no writes until the next (0, 0); that frame then completes normally.
- Frame with pixel (10, 3) followed by (12, 3):
  - err_seq=1;
  - writes stop after address 3*320+10=970 drains;
  - no frame_done;
  - the next clean frame completes and frame_count increments.
- mem_ack low for 40 cycles mid-row, with FIFO_DEPTH=16 and continuous input:
  - overflow=1;
  - mem_addr/mem_data stable throughout the stall;
  - later words keep correct addresses (no shift);
  - frame_done still fires.
- reset_n pulsed low mid-FLUSH: all outputs return to reset values in the same cycle; the next full frame gives frame_count=1.
- With STEREO_SINK_STATS_EN, repeat the stall test: drop_count equals the number of cycles overflow-pushes were rejected.
